// File: rtl/csp_reset_seq_pkg.sv
// Shared types and constants for the CSP reset/start/step sequencer.
// Holds the sequencer state encoding, default hold lengths and the port-width helper.
package csp_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_HOLD_RST,
        ST_HOLD_START,
        ST_RUN
    } seq_state_t;

    localparam int DEF_RESET_CYCLES = 10;
    localparam int DEF_START_CYCLES = 10;

    // Zero-width groups still need a one-bit port.
    function automatic int max1(input int n);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/csp_reset_sync.sv
// Reset-release synchronizer: the chain clears asynchronously on reset and
// fills with ones on clk, so the release output deasserts only in sync with clk.
module csp_reset_sync
    import csp_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic released
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign released = chain[SYNC_STAGES-1];

endmodule

// File: rtl/csp_reset_seq.sv
// Clocked reset/start/step sequencer for csp2verilog-generated process instances.
// Optional step handshake enabled by defining CAST2VERILOG_STEP_CTRL_EN.
module csp_reset_seq
    import csp_reset_seq_pkg::*;
#(
    parameter int RESETS       = 1,
    parameter int STARTS       = 0,
    parameter int STEPS        = 0,
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int START_CYCLES = DEF_START_CYCLES,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_req,
    output logic                    step_ack,
    output logic [RESETS-1:0]       reset_n,
    output logic [max1(STARTS)-1:0] start_n,
    output logic [max1(STEPS)-1:0]  step_n,
    output logic [CNT_W-1:0]        step_count,
    output logic                    done
);

    generate
        if (RESETS < 1 || SYNC_STAGES < 2 || RESET_CYCLES < 1 || START_CYCLES < 1) begin : g_bad_param
            $error("csp_reset_seq: illegal parameter value");
        end
        if (CNT_W < 31) begin : g_cnt_chk
            if (RESET_CYCLES > (1 << CNT_W) || START_CYCLES > (1 << CNT_W)) begin : g_cnt_small
                $error("csp_reset_seq: RESET_CYCLES/START_CYCLES do not fit in CNT_W");
            end
        end
    endgenerate

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);

    logic             released;
    seq_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             rst_rel, rst_rel_nx;
    logic             start_rel, start_rel_nx;
    logic             done_q, done_nx;

    csp_reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .released(released)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SYNC;
            cnt       <= '0;
            rst_rel   <= 1'b0;
            start_rel <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rst_rel   <= rst_rel_nx;
            start_rel <= start_rel_nx;
            done_q    <= done_nx;
        end
    end

    // Release flags are set on the transition edge so the outputs stay registered.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rst_rel_nx   = rst_rel;
        start_rel_nx = start_rel;
        done_nx      = done_q;
        case (state)
            ST_SYNC: begin
                if (released) begin
                    state_nx = ST_HOLD_RST;
                    cnt_nx   = '0;
                end
            end
            ST_HOLD_RST: begin
                if (cnt == RST_LAST) begin
                    state_nx   = ST_HOLD_START;
                    cnt_nx     = '0;
                    rst_rel_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_HOLD_START: begin
                if (cnt == START_LAST) begin
                    state_nx     = ST_RUN;
                    cnt_nx       = '0;
                    start_rel_nx = 1'b1;
                    done_nx      = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                state_nx = ST_RUN;
            end
            default: begin
                state_nx = ST_SYNC;
            end
        endcase
    end

`ifdef CAST2VERILOG_STEP_CTRL_EN
    logic             ack_q;
    logic [CNT_W-1:0] steps_q;
    logic             take_step;

    // A request is accepted only while no ack is showing, so a held request steps every other cycle.
    assign take_step = (state == ST_RUN) && step_req && !ack_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q   <= 1'b0;
            steps_q <= '0;
        end else begin
            ack_q <= take_step;
            if (take_step && (steps_q != '1)) begin
                steps_q <= steps_q + CNT_W'(1);
            end
        end
    end

    assign step_ack   = ack_q;
    assign step_count = steps_q;
`else
    logic unused_step_req;
    assign unused_step_req = step_req;
    assign step_ack        = 1'b0;
    assign step_count      = '0;
`endif

    assign reset_n = {RESETS{rst_rel}};
    assign done    = done_q;

    generate
        if (STARTS > 0) begin : g_start
            assign start_n = {STARTS{start_rel}};
        end else begin : g_no_start
            assign start_n = 1'b0;
        end
        if (STEPS > 0) begin : g_step
`ifdef CAST2VERILOG_STEP_CTRL_EN
            assign step_n = {STEPS{ack_q}};
`else
            assign step_n = {STEPS{start_rel}};
`endif
        end else begin : g_no_step
            assign step_n = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_csp_reset_seq.sv
// Randomized bench for csp_reset_seq: two configurations against an edge-count reference model.
// Expectations follow CAST2VERILOG_STEP_CTRL_EN the same way the design does.
module tb_csp_reset_seq;

    logic clk;
    logic rst;
    logic req_a, req_b;

    logic        ack_a, ack_b;
    logic [1:0]  reset_n_a;
    logic [0:0]  reset_n_b;
    logic [0:0]  start_n_a, start_n_b;
    logic [1:0]  step_n_a;
    logic [0:0]  step_n_b;
    logic [15:0] count_a;
    logic [1:0]  count_b;
    logic        done_a, done_b;

    csp_reset_seq #(
        .RESETS(2), .STARTS(1), .STEPS(2), .SYNC_STAGES(2),
        .RESET_CYCLES(10), .START_CYCLES(10), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(rst), .step_req(req_a), .step_ack(ack_a),
        .reset_n(reset_n_a), .start_n(start_n_a), .step_n(step_n_a),
        .step_count(count_a), .done(done_a)
    );

    csp_reset_seq #(
        .RESETS(1), .STARTS(0), .STEPS(1), .SYNC_STAGES(3),
        .RESET_CYCLES(1), .START_CYCLES(1), .CNT_W(2)
    ) dut_b (
        .clk(clk), .reset(rst), .step_req(req_b), .step_ack(ack_b),
        .reset_n(reset_n_b), .start_n(start_n_b), .step_n(step_n_b),
        .step_count(count_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: index of the last clock edge seen since reset release (-1 = none yet).
    int sync_st[2]  = '{2, 3};
    int rst_cyc[2]  = '{10, 1};
    int strt_cyc[2] = '{10, 1};
    int cnt_max[2]  = '{65535, 3};
    int n_edge[2];
    bit m_ack[2];
    int m_cnt[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            n_edge[i] = -1;
            m_ack[i]  = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_edge(input int i, input bit req);
        int run_edge;
        n_edge[i]++;
        run_edge = sync_st[i] + rst_cyc[i] + strt_cyc[i];
`ifdef CAST2VERILOG_STEP_CTRL_EN
        if (n_edge[i] > run_edge && req && !m_ack[i]) begin
            m_ack[i] = 1'b1;
            if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        end else begin
            m_ack[i] = 1'b0;
        end
`else
        m_ack[i] = 1'b0;
        m_cnt[i] = 0;
`endif
    endtask

    task automatic check_all();
        bit rn[2], sn[2];
        for (int i = 0; i < 2; i++) begin
            rn[i] = (n_edge[i] >= sync_st[i] + rst_cyc[i]);
            sn[i] = (n_edge[i] >= sync_st[i] + rst_cyc[i] + strt_cyc[i]);
        end
        check_eq("a_reset_n", 32'(reset_n_a), rn[0] ? 32'h3 : 32'h0);
        check_eq("a_start_n", 32'(start_n_a), 32'(sn[0]));
        check_eq("a_done", 32'(done_a), 32'(sn[0]));
        check_eq("a_step_ack", 32'(ack_a), 32'(m_ack[0]));
        check_eq("a_step_count", 32'(count_a), 32'(m_cnt[0]));
        check_eq("b_reset_n", 32'(reset_n_b), 32'(rn[1]));
        check_eq("b_start_n", 32'(start_n_b), 32'h0);
        check_eq("b_done", 32'(done_b), 32'(sn[1]));
        check_eq("b_step_ack", 32'(ack_b), 32'(m_ack[1]));
        check_eq("b_step_count", 32'(count_b), 32'(m_cnt[1]));
`ifdef CAST2VERILOG_STEP_CTRL_EN
        check_eq("a_step_n", 32'(step_n_a), m_ack[0] ? 32'h3 : 32'h0);
        check_eq("b_step_n", 32'(step_n_b), 32'(m_ack[1]));
`else
        check_eq("a_step_n", 32'(step_n_a), sn[0] ? 32'h3 : 32'h0);
        check_eq("b_step_n", 32'(step_n_b), 32'(sn[1]));
`endif
    endtask

    // mode 0: no requests, mode 1: random requests (mix of pulses and held runs)
    task automatic run_cycles(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            if (!rst) begin
                model_edge(0, req_a);
                model_edge(1, req_b);
            end
            #1;
            check_all();
            if (mode == 0) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end else begin
                req_a = ($urandom_range(0, 3) != 0);
                req_b = ($urandom_range(0, 1) != 0);
            end
        end
    endtask

    task automatic async_pulse();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        model_reset();
        #1;
        check_all();
        run_cycles(3, 1);
        rst = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        run_cycles(30, 0);
        run_cycles(80, 1);

        // Long reset, then a sub-cycle pulse while dut_a is holding start.
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        run_cycles(2, 1);
        rst = 1'b0;
        run_cycles(16, 1);
        async_pulse();
        run_cycles(40, 0);
        run_cycles(60, 1);

        // Short glitch while both instances are running.
        async_pulse();
        run_cycles(60, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
